// File: rtl/reg_file_sync_if.sv
// Register-file access bus: one write port and two read ports.
interface reg_file_sync_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] INADDRESS;
    logic              WRITE;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;

    // Requester side (ALU / control).
    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2
    );

    // Register-file side.
    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2
    );
endinterface

// File: rtl/reg_file_sync.sv
// 2**ADDR_W x DATA_W register file, one write port, two registered read ports.
// Synchronous active-high reset clears the array and both outputs.
module reg_file_sync #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    reg_file_sync_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] out1_q;
    logic [DATA_W-1:0] out2_q;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic              hit1_c;
    logic              hit2_c;

    // Read-data select: forward write data on an address match when bypass is enabled.
    always_comb begin
        hit1_c = 1'b0;
        hit2_c = 1'b0;
        rd1_c  = regs[bus.OUT1ADDRESS];
        rd2_c  = regs[bus.OUT2ADDRESS];
        if (BYPASS) begin
            hit1_c = bus.WRITE && (bus.OUT1ADDRESS == bus.INADDRESS);
            hit2_c = bus.WRITE && (bus.OUT2ADDRESS == bus.INADDRESS);
        end
        if (hit1_c) rd1_c = bus.IN;
        if (hit2_c) rd2_c = bus.IN;
    end

    // Register array; reset wins over a write presented in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WRITE) begin
            regs[bus.INADDRESS] <= bus.IN;
        end
    end

    // Registered read ports, stable for a full cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            out1_q <= rd1_c;
            out2_q <= rd2_c;
        end
    end

    assign bus.OUT1 = out1_q;
    assign bus.OUT2 = out2_q;
endmodule

// File: tb/tb_reg_file_sync.sv
// Directed bench: drives a bypassing and a non-bypassing register file in lockstep.
module tb_reg_file_sync;
    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [2:0] wa;
    logic       we;
    logic [2:0] ra1;
    logic [2:0] ra2;
    int         n_tests;
    int         n_fail;

    reg_file_sync_if #(.DATA_W(8), .ADDR_W(3)) bus_a ();
    reg_file_sync_if #(.DATA_W(8), .ADDR_W(3)) bus_b ();

    assign bus_a.IN          = din;
    assign bus_a.INADDRESS   = wa;
    assign bus_a.WRITE       = we;
    assign bus_a.OUT1ADDRESS = ra1;
    assign bus_a.OUT2ADDRESS = ra2;
    assign bus_b.IN          = din;
    assign bus_b.INADDRESS   = wa;
    assign bus_b.WRITE       = we;
    assign bus_b.OUT1ADDRESS = ra1;
    assign bus_b.OUT2ADDRESS = ra2;

    reg_file_sync #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) dut_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_a.slave)
    );

    reg_file_sync #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0)) dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [2:0] a, input logic [7:0] d,
                         input logic [2:0] r1, input logic [2:0] r2);
        we  = w;
        wa  = a;
        din = d;
        ra1 = r1;
        ra2 = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        rst = 1'b0;
        n_tests++;
        if (bus_a.OUT1 !== 8'h00 || bus_a.OUT2 !== 8'h00 || bus_b.OUT1 !== 8'h00 || bus_b.OUT2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_init got a=%h/%h b=%h/%h exp 00/00", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
        cycle(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0);
        cycle(1'b1, 3'd7, 8'h3C, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 3'd3, 3'd7);
        n_tests++;
        if (bus_a.OUT1 !== 8'hA5 || bus_a.OUT2 !== 8'h3C || bus_b.OUT1 !== 8'hA5 || bus_b.OUT2 !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_preload got a=%h/%h b=%h/%h exp a5/3c", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
        rst = 1'b1;
        cycle(1'b1, 3'd3, 8'hFF, 3'd3, 3'd7);
        rst = 1'b0;
        n_tests++;
        if (bus_a.OUT1 !== 8'h00 || bus_a.OUT2 !== 8'h00 || bus_b.OUT1 !== 8'h00 || bus_b.OUT2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out got a=%h/%h b=%h/%h exp 00/00", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
        cycle(1'b0, 3'd0, 8'h00, 3'd3, 3'd7);
        n_tests++;
        if (bus_a.OUT1 !== 8'h00 || bus_a.OUT2 !== 8'h00 || bus_b.OUT1 !== 8'h00 || bus_b.OUT2 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_clear got a=%h/%h b=%h/%h exp 00/00", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
    endtask

    task automatic test_write_read();
        cycle(1'b1, 3'd2, 8'h5A, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 3'd2, 3'd0);
        n_tests++;
        if (bus_a.OUT1 !== 8'h5A || bus_b.OUT1 !== 8'h5A) begin
            n_fail++;
            $display("FAIL write_read got a=%h b=%h exp 5a", bus_a.OUT1, bus_b.OUT1);
        end
    endtask

    task automatic test_dual_port();
        cycle(1'b1, 3'd1, 8'h11, 3'd0, 3'd0);
        cycle(1'b1, 3'd6, 8'hEE, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 3'd1, 3'd6);
        n_tests++;
        if (bus_a.OUT1 !== 8'h11 || bus_a.OUT2 !== 8'hEE || bus_b.OUT1 !== 8'h11 || bus_b.OUT2 !== 8'hEE) begin
            n_fail++;
            $display("FAIL dual_port got a=%h/%h b=%h/%h exp 11/ee", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
        cycle(1'b0, 3'd0, 8'h00, 3'd6, 3'd1);
        n_tests++;
        if (bus_a.OUT1 !== 8'hEE || bus_a.OUT2 !== 8'h11 || bus_b.OUT1 !== 8'hEE || bus_b.OUT2 !== 8'h11) begin
            n_fail++;
            $display("FAIL dual_swap got a=%h/%h b=%h/%h exp ee/11", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
    endtask

    task automatic test_bypass();
        cycle(1'b1, 3'd4, 8'h10, 3'd0, 3'd0);
        cycle(1'b1, 3'd4, 8'h99, 3'd4, 3'd4);
        n_tests++;
        if (bus_a.OUT1 !== 8'h99 || bus_a.OUT2 !== 8'h99) begin
            n_fail++;
            $display("FAIL bypass_on got %h/%h exp 99/99", bus_a.OUT1, bus_a.OUT2);
        end
        n_tests++;
        if (bus_b.OUT1 !== 8'h10 || bus_b.OUT2 !== 8'h10) begin
            n_fail++;
            $display("FAIL bypass_off got %h/%h exp 10/10", bus_b.OUT1, bus_b.OUT2);
        end
        cycle(1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
        n_tests++;
        if (bus_a.OUT1 !== 8'h99 || bus_a.OUT2 !== 8'h99 || bus_b.OUT1 !== 8'h99 || bus_b.OUT2 !== 8'h99) begin
            n_fail++;
            $display("FAIL bypass_after got a=%h/%h b=%h/%h exp 99/99", bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
        end
    endtask

    task automatic test_write_disabled();
        cycle(1'b1, 3'd5, 8'h42, 3'd0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 3'd5, 8'h77, 3'd5, 3'd5);
            n_tests++;
            if (bus_a.OUT1 !== 8'h42 || bus_a.OUT2 !== 8'h42 || bus_b.OUT1 !== 8'h42 || bus_b.OUT2 !== 8'h42) begin
                n_fail++;
                $display("FAIL write_disabled[%0d] got a=%h/%h b=%h/%h exp 42/42", k, bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
            end
        end
    endtask

    task automatic test_sweep_reset();
        logic [7:0] e1;
        logic [7:0] e2;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 8'(8 * i + 1), 3'd0, 3'd0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
            e1 = 8'(8 * i + 1);
            e2 = 8'(8 * (7 - i) + 1);
            n_tests++;
            if (bus_a.OUT1 !== e1 || bus_a.OUT2 !== e2 || bus_b.OUT1 !== e1 || bus_b.OUT2 !== e2) begin
                n_fail++;
                $display("FAIL sweep[%0d] got a=%h/%h b=%h/%h exp %h/%h", i, bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2, e1, e2);
            end
        end
        cycle(1'b1, 3'd0, 8'hAA, 3'd0, 3'd0);
        cycle(1'b1, 3'd1, 8'hBB, 3'd0, 3'd0);
        rst = 1'b1;
        cycle(1'b1, 3'd2, 8'hCC, 3'd2, 3'd2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
            n_tests++;
            if (bus_a.OUT1 !== 8'h00 || bus_a.OUT2 !== 8'h00 || bus_b.OUT1 !== 8'h00 || bus_b.OUT2 !== 8'h00) begin
                n_fail++;
                $display("FAIL sweep_reset[%0d] got a=%h/%h b=%h/%h exp 00/00", i, bus_a.OUT1, bus_a.OUT2, bus_b.OUT1, bus_b.OUT2);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        we  = 1'b0;
        wa  = 3'd0;
        din = 8'h00;
        ra1 = 3'd0;
        ra2 = 3'd0;
        test_reset();
        test_write_read();
        test_dual_port();
        test_bypass();
        test_write_disabled();
        test_sweep_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
